mat_loader: RTL

Upstream feeder for the matrix operation unit. Parses a byte stream from the UART receive path (rows, cols, then row-major signed 8-bit elements) into a staging buffer, and commits it atomically to matrix slot A or B. It presents both slots as flat 25-element buses with their dimensions to the operation unit. Commit is held off while the operation unit is busy, so operands never change mid-operation.

---
 rtl/mat_loader_pkg.sv | 34 +++
 rtl/mat_loader_if.sv | 36 +++
 rtl/mat_loader_timeout.sv | 36 +++
 rtl/mat_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mat_loader_pkg.sv
// Shared definitions for the matrix loader: geometry, widths, FSM states and
// the committed-slot payload.
package mat_loader_pkg;

  localparam int unsigned MAX_DIM     = 5;
  localparam int unsigned ELEM_W      = 8;
  localparam int unsigned NUM_ELEM    = MAX_DIM * MAX_DIM;
  localparam int unsigned SLOT_W      = NUM_ELEM * ELEM_W;
  localparam int unsigned DIM_W       = 3;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 50000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GET_N       = 2'd1,
    ST_GET_ELEM    = 2'd2,
    ST_COMMIT_WAIT = 2'd3
  } state_t;

  // One committed matrix slot as seen by the operation unit.
  typedef struct packed {
    logic              valid;
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  n;
    logic [SLOT_W-1:0] data;
  } slot_t;

  // A dimension byte is legal only in 1..MAX_DIM.
  function automatic logic dim_ok(input logic [BYTE_W-1:0] b);
    return (b != BYTE_W'(0)) && (b <= BYTE_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/mat_loader_if.sv
// Byte-stream input, control strobes and slot outputs of the matrix loader.
// master: stream source / operation-unit side; slave: the loader itself.
interface mat_loader_if;
  import mat_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              sel_b;
  logic              clr;
  logic              ops_busy;

  logic [SLOT_W-1:0] matrix_a_flat;
  logic [SLOT_W-1:0] matrix_b_flat;
  logic [DIM_W-1:0]  dim_a_m;
  logic [DIM_W-1:0]  dim_a_n;
  logic [DIM_W-1:0]  dim_b_m;
  logic [DIM_W-1:0]  dim_b_n;
  logic              a_valid;
  logic              b_valid;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output rx_data, rx_valid, sel_b, clr, ops_busy,
    input  matrix_a_flat, matrix_b_flat, dim_a_m, dim_a_n, dim_b_m, dim_b_n,
    input  a_valid, b_valid, load_busy, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid, sel_b, clr, ops_busy,
    output matrix_a_flat, matrix_b_flat, dim_a_m, dim_a_n, dim_b_m, dim_b_n,
    output a_valid, b_valid, load_busy, load_done, load_err
  );

endinterface

// File: rtl/mat_loader_timeout.sv
// Idle watchdog: counts enabled cycles without a restart and flags the cycle
// in which LIMIT idle cycles have elapsed.
//   clk, rst_n : clock, async active-low reset
//   en         : count only while a load is in progress (cleared otherwise)
//   restart    : reload the counter to zero (a byte arrived)
//   expire_c   : combinational, high in the LIMIT-th consecutive idle cycle
module mat_loader_timeout
  import mat_loader_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic expire_c
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  assign expire_c = en && !restart && (cnt_q == W'(LIMIT - 1));

  // Counter returns to zero whenever disabled, restarted or just expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || restart || expire_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/mat_loader.sv
// Matrix loader: parses rows, cols and row-major signed bytes from the UART
// receive stream into a staging buffer and commits it atomically to slot A
// or B once the operation unit is idle.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream input (rx_data/rx_valid/sel_b), clr, ops_busy, and
//                the two slots (flat data, dims, valid) plus load status
module mat_loader
  import mat_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mat_loader_if.slave  bus
);

  state_t            state_q;
  slot_t             slot_a_q;
  slot_t             slot_b_q;
  logic [ELEM_W-1:0] staging_q [NUM_ELEM];
  logic [SLOT_W-1:0] staging_flat_c;
  logic [DIM_W-1:0]  m_q;
  logic [DIM_W-1:0]  n_q;
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  elem_cnt_q;
  logic              target_b_q;
  logic              load_done_q;
  logic              load_err_q;
  logic              in_load_c;
  logic              tmo_expire_c;

  // Watchdog only runs while waiting for dimension/element bytes.
  assign in_load_c = (state_q == ST_GET_N) || (state_q == ST_GET_ELEM);

  mat_loader_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (in_load_c),
    .restart  (bus.rx_valid),
    .expire_c (tmo_expire_c)
  );

  // Staging buffer in the same layout as the output buses.
  always_comb begin
    staging_flat_c = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      staging_flat_c[k*ELEM_W +: ELEM_W] = staging_q[k];
    end
  end

  // Parser / commit FSM. clr overrides everything, including a pending commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_a_q    <= '0;
      slot_b_q    <= '0;
      m_q         <= '0;
      n_q         <= '0;
      total_q     <= '0;
      elem_cnt_q  <= '0;
      target_b_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        staging_q[k] <= '0;
      end
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      if (bus.clr) begin
        state_q    <= ST_IDLE;
        slot_a_q   <= '0;
        slot_b_q   <= '0;
        elem_cnt_q <= '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
          staging_q[k] <= '0;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.rx_valid) begin
              if (dim_ok(bus.rx_data)) begin
                m_q        <= bus.rx_data[DIM_W-1:0];
                target_b_q <= bus.sel_b;
                state_q    <= ST_GET_N;
                // Clearing here keeps unused tail elements zero on commit.
                for (int k = 0; k < NUM_ELEM; k++) begin
                  staging_q[k] <= '0;
                end
              end else begin
                load_err_q <= 1'b1;
              end
            end
          end

          ST_GET_N: begin
            if (bus.rx_valid) begin
              if (dim_ok(bus.rx_data)) begin
                n_q        <= bus.rx_data[DIM_W-1:0];
                total_q    <= CNT_W'(m_q) * CNT_W'(bus.rx_data[DIM_W-1:0]);
                elem_cnt_q <= '0;
                state_q    <= ST_GET_ELEM;
              end else begin
                load_err_q <= 1'b1;
                state_q    <= ST_IDLE;
              end
            end else if (tmo_expire_c) begin
              load_err_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end

          ST_GET_ELEM: begin
            if (bus.rx_valid) begin
              staging_q[elem_cnt_q] <= bus.rx_data;
              elem_cnt_q            <= elem_cnt_q + CNT_W'(1);
              if (elem_cnt_q == total_q - CNT_W'(1)) begin
                state_q <= ST_COMMIT_WAIT;
              end
            end else if (tmo_expire_c) begin
              load_err_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end

          ST_COMMIT_WAIT: begin
            if (!bus.ops_busy) begin
              if (target_b_q) begin
                slot_b_q <= '{valid: 1'b1, m: m_q, n: n_q, data: staging_flat_c};
              end else begin
                slot_a_q <= '{valid: 1'b1, m: m_q, n: n_q, data: staging_flat_c};
              end
              load_done_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.matrix_a_flat = slot_a_q.data;
  assign bus.matrix_b_flat = slot_b_q.data;
  assign bus.dim_a_m       = slot_a_q.m;
  assign bus.dim_a_n       = slot_a_q.n;
  assign bus.dim_b_m       = slot_b_q.m;
  assign bus.dim_b_n       = slot_b_q.n;
  assign bus.a_valid       = slot_a_q.valid;
  assign bus.b_valid       = slot_b_q.valid;
  assign bus.load_done     = load_done_q;
  assign bus.load_err      = load_err_q;
  // Pure decode of the state register.
  assign bus.load_busy     = (state_q != ST_IDLE);

endmodule
